// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a length-prefixed image over UART, writes it to memory
// word by word, and holds the core in reset until the whole image has landed.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int MEM_WORDS    = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL  = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [31:0]   MAX_W = 32'(MEM_WORDS);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {HDR_LO, HDR_HI, LOAD, DONE, ERROR} state_t;
    rx_state_t     rx_state;
    state_t        state;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_sh;
    logic          byte_valid, frame_err;
    logic [15:0]   count, word_index, hdr_n;
    logic [1:0]    byte_cnt;
    logic [31:0]   asm_reg;
    assign hdr_n = {rx_sh, count[7:0]};
    // rx_sh holds the received byte until the next byte's data bits start shifting in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_sh      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= RX_START;
                    cnt      <= CW'(1);
                end
                RX_START: if (cnt == HALF) begin
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    cnt      <= CW'(1);
                    bit_idx  <= '0;
                end else cnt <= cnt + 1'b1;
                RX_DATA: if (cnt == FULL) begin
                    rx_sh    <= {rx_s2, rx_sh[7:1]};
                    cnt      <= CW'(1);
                    bit_idx  <= bit_idx + 3'd1;
                    rx_state <= (bit_idx == 3'd7) ? RX_STOP : RX_DATA;
                end else cnt <= cnt + 1'b1;
                RX_STOP: if (cnt == FULL) begin
                    byte_valid <= rx_s2;
                    frame_err  <= !rx_s2;
                    rx_state   <= RX_IDLE;
                end else cnt <= cnt + 1'b1;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HDR_LO;
            count      <= '0;
            word_index <= '0;
            byte_cnt   <= '0;
            asm_reg    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (frame_err && state != DONE && state != ERROR) begin
                state <= ERROR;
                err   <= 1'b1;
            end else begin
                case (state)
                    HDR_LO: if (byte_valid) begin
                        count[7:0] <= rx_sh;
                        state      <= HDR_HI;
                    end
                    HDR_HI: if (byte_valid) begin
                        count <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            state     <= DONE;
                            cpu_rst_n <= 1'b1;
                            busy      <= 1'b0;
                        end else if ({16'd0, hdr_n} > MAX_W) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else state <= LOAD;
                    end
                    LOAD: if (mem_we) begin
                        if (word_index == count - 16'd1) begin
                            state     <= DONE;
                            cpu_rst_n <= 1'b1;
                            busy      <= 1'b0;
                        end else word_index <= word_index + 16'd1;
                    end else if (byte_valid) begin
                        asm_reg  <= {rx_sh, asm_reg[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {rx_sh, asm_reg[31:8]};
                            mem_addr  <= {14'd0, word_index, 2'b00};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed UART image scenarios with hand-computed memory writes.
module tb_uart_boot_loader;
    localparam int CPB = 16;
    logic        clk, rst_n, uart_rx;
    logic        mem_we, cpu_rst_n, busy, err;
    logic [31:0] mem_addr, mem_wdata;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_n = 0;
    int          last_we = -1;
    int          rise_cyc = -1;
    bit          wide = 0;
    bit          prev_we = 0;
    bit          prev_cpu = 0;
    logic [31:0] wa [8];
    logic [31:0] wd [8];

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(2048)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // write monitor, cleared whenever rst_n is low
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            wr_n = 0; wide = 0; prev_we = 0; prev_cpu = 0; rise_cyc = -1; last_we = -1;
        end else begin
            if (mem_we) begin
                if (wr_n < 8) begin wa[wr_n] = mem_addr; wd[wr_n] = mem_wdata; end
                wr_n = wr_n + 1;
                last_we = cyc;
            end
            if (mem_we && prev_we) wide = 1;
            if (cpu_rst_n && !prev_cpu) rise_cyc = cyc;
            prev_we = mem_we;
            prev_cpu = cpu_rst_n;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        uart_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        uart_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_two_words();
        logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (wr_n !== 2) begin errors++; $display("FAIL two_wr_count: got %0d want 2", wr_n); end
        checks++; if (wa[0] !== 32'h0) begin errors++; $display("FAIL two_addr0: got %h want 00000000", wa[0]); end
        checks++; if (wd[0] !== 32'h00A00513) begin errors++; $display("FAIL two_data0: got %h want 00a00513", wd[0]); end
        checks++; if (wa[1] !== 32'h4) begin errors++; $display("FAIL two_addr1: got %h want 00000004", wa[1]); end
        checks++; if (wd[1] !== 32'h0000006F) begin errors++; $display("FAIL two_data1: got %h want 0000006f", wd[1]); end
        checks++; if (wide !== 1'b0) begin errors++; $display("FAIL two_pulse_width: got wide=%b want 0", wide); end
        checks++; if (rise_cyc !== last_we + 1) begin errors++; $display("FAIL two_cpu_rise: got cycle %0d want %0d", rise_cyc, last_we + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL two_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL two_err: got %b want 0", err); end
    endtask

    task automatic test_zero_header();
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL zero_cpu_rst_n: got %b want 1", cpu_rst_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b0);
        checks++; if (wr_n !== 0) begin errors++; $display("FAIL zero_no_write: got %0d writes want 0", wr_n); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err_after_done: got %b want 0", err); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL zero_stays_done: got %b want 1", cpu_rst_n); end
    endtask

    task automatic test_oversize();
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h08, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL over_err: got %b want 1", err); end
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        checks++; if (wr_n !== 0) begin errors++; $display("FAIL over_no_write: got %0d writes want 0", wr_n); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL over_cpu_rst_n: got %b want 0", cpu_rst_n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL over_busy: got %b want 1", busy); end
    endtask

    task automatic test_framing();
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL frame_err: got %b want 1", err); end
        checks++; if (wr_n !== 0) begin errors++; $display("FAIL frame_no_write: got %0d writes want 0", wr_n); end
        checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL frame_cpu_rst_n: got %b want 0", cpu_rst_n); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL frame_err_cleared: got %b want 0", err); end
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        checks++; if (wr_n !== 1) begin errors++; $display("FAIL frame_reload_count: got %0d want 1", wr_n); end
        checks++; if (wd[0] !== 32'h12345678) begin errors++; $display("FAIL frame_reload_data: got %h want 12345678", wd[0]); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL frame_reload_cpu: got %b want 1", cpu_rst_n); end
    endtask

    task automatic test_glitch();
        do_reset();
        uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        checks++; if (busy !== 1'b1 || cpu_rst_n !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL glitch_state: got busy=%b cpu=%b err=%b want 1 0 0", busy, cpu_rst_n, err);
        end
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h11, 1'b1);
        checks++; if (wr_n !== 1) begin errors++; $display("FAIL glitch_count: got %0d want 1", wr_n); end
        checks++; if (wd[0] !== 32'h11223344) begin errors++; $display("FAIL glitch_data: got %h want 11223344", wd[0]); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL glitch_cpu: got %b want 1", cpu_rst_n); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b1);
        do_reset();
        checks++; if (cpu_rst_n !== 1'b0 || busy !== 1'b1 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL mid_after_reset: got cpu=%b busy=%b addr=%h want 0 1 0", cpu_rst_n, busy, mem_addr);
        end
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        checks++; if (wr_n !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", wr_n); end
        checks++; if (wa[0] !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h want 00000000", wa[0]); end
        checks++; if (wd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_data: got %h want deadbeef", wd[0]); end
        checks++; if (cpu_rst_n !== 1'b1) begin errors++; $display("FAIL mid_cpu: got %b want 1", cpu_rst_n); end
    endtask

    initial begin
        rst_n = 1'b0;
        uart_rx = 1'b1;
        test_reset();
        test_two_words();
        test_zero_header();
        test_oversize();
        test_framing();
        test_glitch();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
